uart_rx: RTL and testbench

UART receiver paired with the existing UART transmitter: 8 data bits, no parity, 1 stop bit, LSB first, bit period set at runtime by a clock-per-bit count. It synchronises the asynchronous RX pin and validates the start bit. Each bit is sampled at mid-period, and a completed byte is held in a single-entry register with a valid/read handshake toward the peripheral bus wrapper. Framing errors and overruns are reported as sticky flags.

---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, no parity, 1 stop bit, LSB first.
// Bit period comes from i_ClksPerBit, latched at each start bit.
// Completed bytes go into a single-entry holding register with a valid/read handshake.
// Framing errors and overruns are reported as sticky flags.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: each bit sample is the 2-of-3 majority
// of rx at counts T-2, T-1 and T. When undefined, rx is sampled only at count T.
module uart_rx (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [15:0] i_ClksPerBit,
  input  logic        i_UART_RX,
  input  logic        i_RdEn,
  input  logic        i_ClrErr,
  output logic [7:0]  o_Data,
  output logic        o_DataValid,
  output logic        o_FrameErr,
  output logic        o_Overrun,
  output logic        o_RxIdle
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd3,
    StWaitHigh = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_q;
  logic [15:0] cpb_q, cnt_q;
  logic [15:0] half, t_eval;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        at_eval, sample;
  logic        stop_ok, stop_bad;
  logic [7:0]  data_q;
  logic        valid_q, frame_err_q, overrun_q;

  // Two-flop synchroniser on the asynchronous line; idles high.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= i_UART_RX;
      rx_q      <= rx_meta_q;
    end
  end

  assign half = cpb_q >> 1;

  // Evaluation count: mid-bit for the start bit, end of period for data and stop.
  always_comb begin
    t_eval = cpb_q - 16'd1;
    if (state_q == StStart) t_eval = half - 16'd1;
  end

  assign at_eval = (cnt_q == t_eval);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote_a_q, vote_b_q;

  // Capture rx at T-2 and T-1; while idle both hold rx, which is 0 on entering start.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      vote_a_q <= 1'b1;
      vote_b_q <= 1'b1;
    end else if (state_q == StIdle) begin
      vote_a_q <= rx_q;
      vote_b_q <= rx_q;
    end else begin
      if (cnt_q == t_eval - 16'd2) vote_a_q <= rx_q;
      if (cnt_q == t_eval - 16'd1) vote_b_q <= rx_q;
    end
  end

  assign sample = (vote_a_q & vote_b_q) | (vote_a_q & rx_q) | (vote_b_q & rx_q);
`else
  assign sample = rx_q;
`endif

  assign stop_ok  = (state_q == StStop) && at_eval && sample;
  assign stop_bad = (state_q == StStop) && at_eval && !sample;

  // State register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (!rx_q) state_d = StStart;
      StStart:    if (at_eval) state_d = sample ? StIdle : StData;
      StData:     if (at_eval && (bit_idx_q == 3'd7)) state_d = StStop;
      StStop:     if (at_eval) state_d = sample ? StIdle : StWaitHigh;
      StWaitHigh: if (rx_q) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Bit-timing counter, bit index, period latch and shift register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      cpb_q     <= 16'd0;
      shift_q   <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q     <= 16'd0;
          bit_idx_q <= 3'd0;
          if (!rx_q) cpb_q <= i_ClksPerBit;
        end
        StStart, StStop: begin
          if (at_eval) cnt_q <= 16'd0;
          else         cnt_q <= cnt_q + 16'd1;
        end
        StData: begin
          if (at_eval) begin
            cnt_q     <= 16'd0;
            bit_idx_q <= bit_idx_q + 3'd1;
            shift_q   <= {sample, shift_q[7:1]};
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: cnt_q <= 16'd0;
      endcase
    end
  end

  // Holding register, read handshake and sticky error flags; a set beats a clear.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (stop_ok) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (i_RdEn) begin
        valid_q <= 1'b0;
      end

      if (stop_ok && valid_q && !i_RdEn) overrun_q <= 1'b1;
      else if (i_ClrErr)                 overrun_q <= 1'b0;

      if (stop_bad)      frame_err_q <= 1'b1;
      else if (i_ClrErr) frame_err_q <= 1'b0;
    end
  end

  // Outputs.
  always_comb begin
    o_RxIdle    = (state_q == StIdle);
    o_Data      = data_q;
    o_DataValid = valid_q;
    o_FrameErr  = frame_err_q;
    o_Overrun   = overrun_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand-written corner sequences and a
// randomized phase checked against frame-timing predictions.
module tb_uart_rx;

  logic        i_Clk;
  logic        i_Rst;
  logic [15:0] i_ClksPerBit;
  logic        i_UART_RX;
  logic        tb_rd, chk_rd;
  logic        i_ClrErr;
  logic [7:0]  o_Data;
  logic        o_DataValid, o_FrameErr, o_Overrun, o_RxIdle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_rx dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_ClksPerBit(i_ClksPerBit),
    .i_UART_RX   (i_UART_RX),
    .i_RdEn      (tb_rd | chk_rd),
    .i_ClrErr    (i_ClrErr),
    .o_Data      (o_Data),
    .o_DataValid (o_DataValid),
    .o_FrameErr  (o_FrameErr),
    .o_Overrun   (o_Overrun),
    .o_RxIdle    (o_RxIdle)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;
  always @(posedge i_Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_UART_RX = 1'b1;
    repeat (n) tick();
  endtask

  // Drives one frame at c clocks per bit. stop_low > 0 holds the stop bit low that long.
  // spike_t forces the line low during that single clock.
  task automatic drive_frame(input logic [7:0] b, input int c, input int stop_low,
                             input int spike_t);
    int len;
    logic lv;
    len = 9 * c + ((stop_low > 0) ? stop_low : c);
    for (int t = 0; t < len; t++) begin
      if (t < c)          lv = 1'b0;
      else if (t < 9 * c) lv = b[(t - c) / c];
      else                lv = (stop_low == 0);
      if (t == spike_t) lv = 1'b0;
      i_UART_RX = lv;
      tick();
    end
  endtask

  task automatic rd_pulse();
    tb_rd = 1'b1;
    tick();
    tb_rd = 1'b0;
  endtask

  task automatic clr_pulse();
    i_ClrErr = 1'b1;
    tick();
    i_ClrErr = 1'b0;
  endtask

  // Two back-to-back frames; rd/clr are driven for exactly the edge that loads the second byte.
  task automatic pair(input logic [7:0] b1, input logic [7:0] b2, input int c,
                      input logic rd, input logic clr);
    fork
      begin
        drive_frame(b1, c, 0, -1);
        drive_frame(b2, c, 0, -1);
      end
      begin
        repeat (10 * c + 2 + c / 2 + 9 * c) tick();
        tb_rd    = rd;
        i_ClrErr = clr;
        tick();
        tb_rd    = 1'b0;
        i_ClrErr = 1'b0;
      end
    join
  endtask

  // Randomized-phase scoreboard: each frame predicts the cycle at which its byte appears.
  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];
  bit   rnd_on = 1'b0;
  bit   rd_pending = 1'b0;

  initial chk_rd = 1'b0;

  always begin
    @(posedge i_Clk);
    #1;
    if (rd_pending) begin
      chk_rd     = 1'b0;
      rd_pending = 1'b0;
      check("rnd read clears valid", {31'd0, o_DataValid}, 32'd0);
    end
    if (rnd_on && exp_q.size() > 0) begin
      if (cyc == exp_q[0].cyc - 1) begin
        check("rnd valid before load", {31'd0, o_DataValid}, 32'd0);
      end else if (cyc == exp_q[0].cyc) begin
        check("rnd valid at load", {31'd0, o_DataValid}, 32'd1);
        check("rnd data", {24'd0, o_Data}, {24'd0, exp_q[0].data});
        check("rnd flags clear", {30'd0, o_FrameErr, o_Overrun}, 32'd0);
        chk_rd     = 1'b1;
        rd_pending = 1'b1;
        void'(exp_q.pop_front());
      end
    end
  end

  typedef struct {
    int         cpb;
    logic [7:0] data;
    int         stop_low;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[7];

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int         c, gap;
    logic [7:0] b;
    logic [7:0] maj_exp;
    exp_t       e;

    vecs[0] = '{16, 8'hA5, 0,  8'hA5, 1'b1, 1'b0};
    vecs[1] = '{4,  8'h00, 0,  8'h00, 1'b1, 1'b0};
    vecs[2] = '{5,  8'hFF, 0,  8'hFF, 1'b1, 1'b0};
    vecs[3] = '{7,  8'h81, 0,  8'h81, 1'b1, 1'b0};
    vecs[4] = '{16, 8'h3C, 32, 8'h81, 1'b0, 1'b1};
    vecs[5] = '{33, 8'h6E, 0,  8'h6E, 1'b1, 1'b0};
    vecs[6] = '{4,  8'hC3, 20, 8'h6E, 1'b0, 1'b1};

    i_Rst        = 1'b1;
    i_ClksPerBit = 16'd16;
    i_UART_RX    = 1'b1;
    tb_rd        = 1'b0;
    i_ClrErr     = 1'b0;
    repeat (3) tick();
    i_Rst = 1'b0;

    check("reset data",     {24'd0, o_Data}, 32'h00);
    check("reset valid",    {31'd0, o_DataValid}, 32'd0);
    check("reset frameerr", {31'd0, o_FrameErr}, 32'd0);
    check("reset overrun",  {31'd0, o_Overrun}, 32'd0);
    check("reset rxidle",   {31'd0, o_RxIdle}, 32'd1);
    idle(4);

    // Nominal 8'hA5 at 16 clocks per bit with exact timing.
    fork
      drive_frame(8'hA5, 16, 0, -1);
      begin
        repeat (2) tick();
        check("nominal idle before E2", {31'd0, o_RxIdle}, 32'd1);
        tick();
        check("nominal idle falls after E2", {31'd0, o_RxIdle}, 32'd0);
        repeat (151) tick();
        check("nominal valid before E154", {31'd0, o_DataValid}, 32'd0);
        tick();
        check("nominal valid after E154", {31'd0, o_DataValid}, 32'd1);
        check("nominal data", {24'd0, o_Data}, 32'hA5);
        check("nominal flags", {30'd0, o_FrameErr, o_Overrun}, 32'd0);
        check("nominal idle back", {31'd0, o_RxIdle}, 32'd1);
      end
    join
    rd_pulse();
    check("nominal read clears valid", {31'd0, o_DataValid}, 32'd0);
    idle(4);

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      i_ClksPerBit = 16'(vecs[i].cpb);
      drive_frame(vecs[i].data, vecs[i].cpb, vecs[i].stop_low, -1);
      idle(3 * vecs[i].cpb);
      check("vec data",     {24'd0, o_Data}, {24'd0, vecs[i].exp_data});
      check("vec valid",    {31'd0, o_DataValid}, {31'd0, vecs[i].exp_valid});
      check("vec frameerr", {31'd0, o_FrameErr}, {31'd0, vecs[i].exp_ferr});
      check("vec overrun",  {31'd0, o_Overrun}, 32'd0);
      tb_rd    = 1'b1;
      i_ClrErr = 1'b1;
      tick();
      tb_rd    = 1'b0;
      i_ClrErr = 1'b0;
      check("vec cleared", {30'd0, o_DataValid, o_FrameErr}, 32'd0);
    end

    // Glitch rejection: 3-clock low pulse.
    i_ClksPerBit = 16'd16;
    i_UART_RX = 1'b0;
    repeat (3) tick();
    i_UART_RX = 1'b1;
    tick();
    check("glitch enters start", {31'd0, o_RxIdle}, 32'd0);
    repeat (40) tick();
    check("glitch back to idle", {31'd0, o_RxIdle}, 32'd1);
    check("glitch no byte/err", {30'd0, o_DataValid, o_FrameErr}, 32'd0);

    // Framing error with a 20-bit-time break.
    fork
      drive_frame(8'h3C, 16, 320, -1);
      begin
        repeat (160) tick();
        check("break frameerr", {31'd0, o_FrameErr}, 32'd1);
        check("break valid", {31'd0, o_DataValid}, 32'd0);
        check("break busy", {31'd0, o_RxIdle}, 32'd0);
      end
    join
    i_UART_RX = 1'b1;
    repeat (3) tick();
    check("break released idle", {31'd0, o_RxIdle}, 32'd1);
    check("break flag sticky", {31'd0, o_FrameErr}, 32'd1);
    clr_pulse();
    check("clrerr frameerr", {31'd0, o_FrameErr}, 32'd0);
    idle(4);

    // Overrun, with a clear on the same edge (set wins).
    pair(8'h11, 8'h22, 16, 1'b0, 1'b1);
    idle(8);
    check("overrun data", {24'd0, o_Data}, 32'h22);
    check("overrun flag", {31'd0, o_Overrun}, 32'd1);
    check("overrun valid", {31'd0, o_DataValid}, 32'd1);
    clr_pulse();
    check("overrun cleared", {31'd0, o_Overrun}, 32'd0);
    rd_pulse();
    check("read with no byte", {31'd0, o_DataValid}, 32'd0);
    rd_pulse();
    check("read when empty", {31'd0, o_DataValid}, 32'd0);

    // Read on the same edge as the second load: no overrun.
    pair(8'h11, 8'h44, 16, 1'b1, 1'b0);
    idle(8);
    check("same-edge read data", {24'd0, o_Data}, 32'h44);
    check("same-edge read valid", {31'd0, o_DataValid}, 32'd1);
    check("same-edge read no overrun", {31'd0, o_Overrun}, 32'd0);

    // Reset during data bit 4, holding reset until the frame ends.
    fork
      drive_frame(8'h77, 16, 0, -1);
      begin
        repeat (88) tick();
        i_Rst = 1'b1;
        tick();
        check("midreset data", {24'd0, o_Data}, 32'h00);
        check("midreset valid/flags", {29'd0, o_DataValid, o_FrameErr, o_Overrun}, 32'd0);
        check("midreset idle", {31'd0, o_RxIdle}, 32'd1);
      end
    join
    i_Rst = 1'b0;
    idle(5);
    drive_frame(8'h5A, 16, 0, -1);
    idle(32);
    check("after reset data", {24'd0, o_Data}, 32'h5A);
    check("after reset valid", {31'd0, o_DataValid}, 32'd1);
    rd_pulse();

    // Single-clock low spike at the bit-0 decision point of 8'hFF.
`ifdef UART_RX_MAJORITY_VOTE_EN
    maj_exp = 8'hFF;
`else
    maj_exp = 8'hFE;
`endif
    drive_frame(8'hFF, 16, 0, 24);
    idle(32);
    check("spike data", {24'd0, o_Data}, {24'd0, maj_exp});
    rd_pulse();
    clr_pulse();
    idle(4);

    // Randomized frames with random bit periods and gaps (including zero gap).
    rnd_on = 1'b1;
    for (int f = 0; f < 30; f++) begin
      c   = int'($urandom_range(4, 24));
      gap = int'($urandom_range(0, 2 * c));
      b   = 8'($urandom);
      idle(gap);
      i_ClksPerBit = 16'(c);
      e.cyc  = cyc + 3 + c / 2 + 9 * c;
      e.data = b;
      exp_q.push_back(e);
      drive_frame(b, c, 0, -1);
    end
    i_UART_RX = 1'b1;
    for (int k = 0; k < 2000 && exp_q.size() > 0; k++) tick();
    check("rnd all bytes seen", exp_q.size(), 32'd0);
    repeat (3) tick();
    rnd_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
